// File: rtl/booth_pkg.sv
// Shared types and the radix-4 Booth recode table for the booth_mul datapath.
// The recode function maps a {q1,q0,q-1} triplet to a signed digit select.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } booth_state_t;

  typedef enum logic [2:0] {
    ZERO,
    P1,
    P2,
    M1,
    M2
  } booth_sel_t;

  function automatic booth_sel_t booth_recode(input logic [2:0] bits);
    booth_sel_t r;
    r = ZERO;
    unique case (bits)
      3'b001, 3'b010: r = P1;
      3'b011:         r = P2;
      3'b100:         r = M2;
      3'b101, 3'b110: r = M1;
      default:        r = ZERO;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: picks the addend magnitude (0, M, 2M) and sign.
// The caller inverts the magnitude and injects neg as carry-in.
module booth_r4_enc
  import booth_pkg::*;
#(
  parameter int W = 18
) (
  input  logic [2:0]   bits,
  input  logic [W-1:0] m,
  output logic [W-1:0] mag,
  output logic         neg
);

  booth_sel_t sel;

  assign sel = booth_recode(bits);

  always_comb begin
    mag = '0;
    neg = 1'b0;
    unique case (sel)
      ZERO: mag = '0;
      P1:   mag = m;
      P2:   mag = {m[W-2:0], 1'b0};
      M1: begin
        mag = m;
        neg = 1'b1;
      end
      M2: begin
        mag = {m[W-2:0], 1'b0};
        neg = 1'b1;
      end
      default: mag = '0;
    endcase
  end

endmodule

// File: rtl/rca.sv
// Ripple-carry adder used as the Booth accumulator adder.
// Carry chain built from per-bit full adders.
module RCA #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Carry_i,
  output logic [N-1:0] S,
  output logic         Carry_o
);

  logic [N:0] c;

  assign c[0] = Carry_i;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Carry_o = c[N];

endmodule

// File: rtl/booth_r4_seq.sv
// Sequential radix-4 Booth multiplier, two multiplier bits per cycle.
// Define BOOTH_EARLY_TERM_EN to exit early once the remaining recodes are all zero.
module booth_r4_seq
  import booth_pkg::*;
#(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p_o
);

  localparam int W  = N + 2;
  localparam int SW = (N / 2 > 1) ? $clog2(N / 2) : 1;

  booth_state_t  state;
  logic [W-1:0]  m_q;
  logic [W-1:0]  h_q;
  logic [N-1:0]  q_q;
  logic          qm1_q;
  logic [SW-1:0] step_q;

  logic [W-1:0]  mag;
  logic [W-1:0]  b_op;
  logic [W-1:0]  s;
  logic          neg;
  logic          carry_unused;
  logic          last;
  logic [W-1:0]  h_nx;
  logic [N-1:0]  q_nx;

  booth_r4_enc #(.W(W)) u_enc (
    .bits ({q_q[1:0], qm1_q}),
    .m    (m_q),
    .mag  (mag),
    .neg  (neg)
  );

  assign b_op = mag ^ {W{neg}};

  RCA #(.N(W)) u_rca (
    .A       (h_q),
    .B       (b_op),
    .Carry_i (neg),
    .S       (s),
    .Carry_o (carry_unused)
  );

  assign in_ready = (state == IDLE);
  assign last     = (step_q == SW'(N / 2 - 1));
  assign h_nx     = {{2{s[W-1]}}, s[W-1:2]};
  assign q_nx     = {s[1:0], q_q[N-1:2]};

`ifdef BOOTH_EARLY_TERM_EN
  logic [N-1:0]   mask;
  logic           early;
  logic [W+N-1:0] hq_sh;

  // Unconsumed multiplier bits sit in the low N-2*step bits of Q.
  assign mask  = {N{1'b1}} >> {step_q, 1'b0};
  assign early = qm1_q ? ((q_q & mask) == mask)
                       : ((q_q & mask) == '0);
  assign hq_sh = $signed({h_q, q_q}) >>> (N - 2 * int'(step_q));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      p_o       <= '0;
      m_q       <= '0;
      h_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      step_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            m_q    <= {{2{a_i[N-1]}}, a_i};
            h_q    <= '0;
            q_q    <= b_i;
            qm1_q  <= 1'b0;
            step_q <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
`ifdef BOOTH_EARLY_TERM_EN
          if (early) begin
            h_q       <= hq_sh[W+N-1:N];
            q_q       <= hq_sh[N-1:0];
            p_o       <= {hq_sh[2*N-1:N], hq_sh[N-1:0]};
            out_valid <= 1'b1;
            state     <= DONE;
          end else
`endif
          begin
            h_q    <= h_nx;
            q_q    <= q_nx;
            qm1_q  <= q_q[1];
            step_q <= step_q + 1'b1;
            if (last) begin
              p_o       <= {h_nx[N-1:0], q_nx};
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_seq.sv
// Self-checking bench for booth_r4_seq (N=16): directed table, corner
// sequences and random pairs against a plain a*b reference.
module tb_booth_r4_seq;

  localparam int N = 16;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a_i;
  logic [N-1:0]   b_i;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] p_o;

  int vectors;
  int miscompares;

  booth_r4_seq #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_i       (a_i),
    .b_i       (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p_o       (p_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] p;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a,
                                             input logic [N-1:0] b);
    logic signed [2*N-1:0] r;
    r = $signed(a) * $signed(b);
    return r;
  endfunction

  // Latency counted from the accept cycle (inclusive) to the first
  // cycle in which out_valid is seen high.
  function automatic int ref_lat(input logic [N-1:0] b);
`ifdef BOOTH_EARLY_TERM_EN
    logic [N:0] bx;
    logic [N:0] r;
    logic [N:0] ones;
    bx   = {b, 1'b0};
    ones = '1;
    for (int k = 0; k < N / 2; k++) begin
      r = bx >> (2 * k);
      if (r == '0 || r == (ones >> (2 * k))) return k + 2;
    end
    return N / 2 + 1;
`else
    return (b == b) ? N / 2 + 1 : 0;
`endif
  endfunction

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic rdy, output logic [2*N-1:0] p,
                        output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL in_ready_wait: got 0, expected 1");
    end
    a_i       = a;
    b_i       = b;
    in_valid  = 1'b1;
    out_ready = rdy;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL out_valid_timeout: got 0, expected 1");
    end
    p = p_o;
    if (rdy) begin
      @(posedge clk); #1;
    end
  endtask

  logic [2*N-1:0] p;
  logic [2*N-1:0] exp_p;
  logic [N-1:0]   ra;
  logic [N-1:0]   rb;
  int             lat;
  logic [N-1:0]   corner[6];

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    a_i         = '0;
    b_i         = '0;

    tbl[0] = '{16'd3,    16'd5,    32'h0000000F};
    tbl[1] = '{16'h8000, 16'h8000, 32'h40000000};
    tbl[2] = '{16'hFFF9, 16'd6,    32'hFFFFFFD6};
    tbl[3] = '{16'd1234, 16'd0,    32'h00000000};
    tbl[4] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
    tbl[5] = '{16'h8000, 16'h7FFF, 32'hC0008000};
    tbl[6] = '{16'd1,    16'hFFFF, 32'hFFFFFFFF};
    tbl[7] = '{16'hFFFF, 16'hFFFF, 32'h00000001};
    tbl[8] = '{16'd0,    16'h8000, 32'h00000000};
    tbl[9] = '{16'h0100, 16'h0040, 32'h00004000};

    corner[0] = 16'h0000;
    corner[1] = 16'hFFFF;
    corner[2] = 16'h8000;
    corner[3] = 16'h7FFF;
    corner[4] = 16'h0001;
    corner[5] = 16'h5555;

    #12;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_p_o", 64'(p_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].a, tbl[i].b, 1'b1, p, lat);
      check($sformatf("tbl%0d_p", i), 64'(p), 64'(tbl[i].p));
      check($sformatf("tbl%0d_lat", i), 64'(lat), 64'(ref_lat(tbl[i].b)));
      check($sformatf("tbl%0d_handoff", i), 64'(out_valid), 64'd0);
    end

    // Backpressure: product held, new operands ignored, one transfer.
    run_op(16'd7, 16'hFFF7, 1'b0, p, lat);
    exp_p = 32'hFFFFFFC1;
    check("bp_p", 64'(p), 64'(exp_p));
    for (int c = 0; c < 5; c++) begin
      a_i      = 16'd99;
      b_i      = 16'd77;
      in_valid = 1'b1;
      @(posedge clk); #1;
      check($sformatf("bp_valid%0d", c), 64'(out_valid), 64'd1);
      check($sformatf("bp_hold%0d", c), 64'(p_o), 64'(exp_p));
      check($sformatf("bp_in_ready%0d", c), 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_ready", 64'(in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("bp_single_xfer", 64'({out_valid, in_ready}), 64'b01);

    // Asynchronous reset in the middle of RUN.
    a_i      = 16'd100;
    b_i      = 16'd200;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_p_o", 64'(p_o), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'd2, 16'd2, 1'b1, p, lat);
    check("rst_next_p", 64'(p), 64'd4);

    // Random signed pairs, biased toward corner operands.
    for (int i = 0; i < 2000; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)]
                                       : N'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)]
                                       : N'($urandom);
      if ($urandom_range(0, 7) == 0) rb = N'($urandom_range(0, 15));
      run_op(ra, rb, 1'b1, p, lat);
      check($sformatf("rnd%0d_p a=%0h b=%0h", i, ra, rb), 64'(p),
            64'(ref_mul(ra, rb)));
      check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(ref_lat(rb)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
